// File: rtl/vect_op_sequencer.sv
// ----------------------------------------------------------------------------
// vect_op_sequencer
//
// Purpose:
//   Issues a single vector command to the shared vect_unit datapath, one
//   element at a time. For element i it reads registers src_a+i and src_b+i,
//   registers them as the vect_unit operands, and then writes the result to
//   register dst+i. Every register address wraps modulo 32. Each element is
//   fully written back before the next element is read, so vectors that are
//   in place or overlap behave exactly like the equivalent sequential loop.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               command strobe; sampled only in IDLE
//   op                  aluCTRL code applied to every element
//   src_a, src_b, dst   base register addresses of the A, B and result vectors
//   len                 element count (values above 32 are treated as 32)
//   busy                high in ISSUE / WRITE / DONE
//   done                one-cycle pulse in the final (DONE) cycle
//   flags_acc           sticky OR of alu_flags over the written elements
//   rf_ra_a, rf_ra_b    register-file read addresses (valid in ISSUE)
//   rf_rd_a, rf_rd_b    register-file read data (combinational read)
//   alu_a, alu_b        registered operands to vect_unit
//   alu_ctrl            registered op to vect_unit
//   alu_out, alu_flags  vect_unit result and flags
//   rf_we, rf_wa, rf_wd register-file write port (rf_wd = alu_out)
//
// Optional build macro:
//   VSEQ_ABORT_EN  adds input abort and output aborted. When abort is high in
//                  ISSUE, or in WRITE (where it also gates rf_we off), the
//                  command ends early through DONE. aborted rises with done
//                  and holds until the next accepted start.
//
// Handshake: there is no ready. A start pulse is taken only while the
// sequencer is IDLE (busy=0). It is ignored while busy, which includes the
// DONE cycle. The issuer watches busy/done to know when the command has ended.
// ----------------------------------------------------------------------------
module vect_op_sequencer #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int LEN_W  = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [3:0]        op,
   input  logic [ADDR_W-1:0] src_a,
   input  logic [ADDR_W-1:0] src_b,
   input  logic [ADDR_W-1:0] dst,
   input  logic [LEN_W-1:0]  len,
`ifdef VSEQ_ABORT_EN
   input  logic              abort,
   output logic              aborted,
`endif
   output logic              busy,
   output logic              done,
   output logic [1:0]        flags_acc,
   output logic [ADDR_W-1:0] rf_ra_a,
   output logic [ADDR_W-1:0] rf_ra_b,
   input  logic [DATA_W-1:0] rf_rd_a,
   input  logic [DATA_W-1:0] rf_rd_b,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_ctrl,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [1:0]        alu_flags,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_wa,
   output logic [DATA_W-1:0] rf_wd
);

   // A command can never touch more than the whole register file.
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        op_q, op_d;
   logic [ADDR_W-1:0] src_a_q, src_a_d;
   logic [ADDR_W-1:0] src_b_q, src_b_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic [1:0]        flags_q, flags_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [3:0]        alu_ctrl_q, alu_ctrl_d;
`ifdef VSEQ_ABORT_EN
   logic              aborted_q, aborted_d;
`endif

   logic [ADDR_W-1:0] idx_addr;
   logic              wr_en;
   logic              last_elem;

   // idx never exceeds 31 while a command runs, so its low bits are the
   // register offset. Adding those bits at ADDR_W width gives the modulo-32 wrap.
   assign idx_addr  = idx_q[ADDR_W-1:0];
   assign last_elem = (idx_q == (len_q - LEN_W'(1)));

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         src_a_q    <= '0;
         src_b_q    <= '0;
         dst_q      <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         flags_q    <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_ctrl_q <= '0;
`ifdef VSEQ_ABORT_EN
         aborted_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         src_a_q    <= src_a_d;
         src_b_q    <= src_b_d;
         dst_q      <= dst_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         flags_q    <= flags_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_ctrl_q <= alu_ctrl_d;
`ifdef VSEQ_ABORT_EN
         aborted_q  <= aborted_d;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      src_a_d    = src_a_q;
      src_b_d    = src_b_q;
      dst_d      = dst_q;
      len_d      = len_q;
      idx_d      = idx_q;
      flags_d    = flags_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_ctrl_d = alu_ctrl_q;
`ifdef VSEQ_ABORT_EN
      aborted_d  = aborted_q;
`endif
      wr_en      = 1'b0;
      rf_ra_a    = '0;
      rf_ra_b    = '0;
      rf_wa      = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               src_a_d = src_a;
               src_b_d = src_b;
               dst_d   = dst;
               len_d   = (len > MAX_LEN) ? MAX_LEN : len;
               idx_d   = '0;
               flags_d = '0;
`ifdef VSEQ_ABORT_EN
               aborted_d = 1'b0;
`endif
               state_d = (len == '0) ? S_DONE : S_ISSUE;
            end
         end

         S_ISSUE: begin
            rf_ra_a    = src_a_q + idx_addr;
            rf_ra_b    = src_b_q + idx_addr;
            alu_a_d    = rf_rd_a;
            alu_b_d    = rf_rd_b;
            alu_ctrl_d = op_q;
            state_d    = S_WRITE;
`ifdef VSEQ_ABORT_EN
            if (abort) begin
               state_d   = S_DONE;
               aborted_d = 1'b1;
            end
`endif
         end

         S_WRITE: begin
            rf_wa = dst_q + idx_addr;
            wr_en = 1'b1;
`ifdef VSEQ_ABORT_EN
            // Abort takes effect in the same cycle, so this element is never
            // written.
            if (abort) begin
               wr_en = 1'b0;
            end
`endif
            if (wr_en) begin
               flags_d = flags_q | alu_flags;
               if (last_elem) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + LEN_W'(1);
                  state_d = S_ISSUE;
               end
            end else begin
               state_d = S_DONE;
`ifdef VSEQ_ABORT_EN
               aborted_d = 1'b1;
`endif
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign rf_we     = wr_en;
   assign rf_wd     = alu_out;
   assign flags_acc = flags_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_ctrl  = alu_ctrl_q;
`ifdef VSEQ_ABORT_EN
   assign aborted   = aborted_q;
`endif

endmodule

// File: tb/tb_vect_op_sequencer.sv
// ----------------------------------------------------------------------------
// tb_vect_op_sequencer
//
// Surrounds vect_op_sequencer with a 32x32 register file and a small
// vect_unit model, then runs a table of vector commands and a few hand-written
// sequences: restart while busy, sticky flags, reset mid-command, and (with
// VSEQ_ABORT_EN) abort. Expected writes come from a sequential reference model
// and are queued when a command is issued. They are checked in order as the
// DUT performs its writes.
// ----------------------------------------------------------------------------
module tb_vect_op_sequencer;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int LEN_W  = 6;
   localparam int EW     = 8 + ADDR_W + DATA_W;   // {cycle, addr, data}

   logic              clk, rst_n, start;
   logic [3:0]        op;
   logic [ADDR_W-1:0] src_a, src_b, dst;
   logic [LEN_W-1:0]  len;
   logic              busy, done;
   logic [1:0]        flags_acc;
   logic [ADDR_W-1:0] rf_ra_a, rf_ra_b, rf_wa;
   logic [DATA_W-1:0] rf_rd_a, rf_rd_b, alu_a, alu_b, alu_out, rf_wd;
   logic [3:0]        alu_ctrl;
   logic [1:0]        alu_flags;
   logic              rf_we;
`ifdef VSEQ_ABORT_EN
   logic              abort, aborted;
`endif

   // register file (environment) and the bench's independent reference copy
   logic [DATA_W-1:0] rf     [32];
   logic [DATA_W-1:0] ref_rf [32];
   logic              tb_we;
   logic [ADDR_W-1:0] tb_wa;
   logic [DATA_W-1:0] tb_wd;

   logic [EW-1:0] exp_q[$];
   int n_vec, n_err;

   vect_op_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .src_a(src_a), .src_b(src_b), .dst(dst), .len(len),
`ifdef VSEQ_ABORT_EN
      .abort(abort), .aborted(aborted),
`endif
      .busy(busy), .done(done), .flags_acc(flags_acc),
      .rf_ra_a(rf_ra_a), .rf_ra_b(rf_ra_b), .rf_rd_a(rf_rd_a), .rf_rd_b(rf_rd_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_out(alu_out), .alu_flags(alu_flags),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- environment models ----------------
   // vect_unit model: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, others pass A.
   // flags[0] = result is zero, flags[1] = ADD carry / SUB borrow.
   function automatic logic [DATA_W+1:0] alu_f(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [3:0] c);
      logic [DATA_W:0]   s;
      logic [DATA_W-1:0] r;
      logic              cf;
      s  = '0;
      r  = a;
      cf = 1'b0;
      case (c)
         4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[DATA_W-1:0]; cf = s[DATA_W]; end
         4'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[DATA_W-1:0]; cf = s[DATA_W]; end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         default: r = a;
      endcase
      return {cf, (r == '0), r};
   endfunction

   assign {alu_flags, alu_out} = alu_f(alu_a, alu_b, alu_ctrl);
   assign rf_rd_a = rf[rf_ra_a];
   assign rf_rd_b = rf[rf_ra_b];

   always @(posedge clk) begin
      if (rf_we)      rf[rf_wa] <= rf_wd;
      else if (tb_we) rf[tb_wa] <= tb_wd;
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
      n_vec++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, expv);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_reg(input int r, input logic [DATA_W-1:0] v);
      ref_rf[r] = v;
      @(negedge clk);
      tb_we = 1'b1;
      tb_wa = ADDR_W'(r);
      tb_wd = v;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   // Runs the reference loop for the first n elements. It updates ref_rf and
   // pushes the expected writes. Write k (k=1..n) lands in cycle 2k.
   task automatic model_cmd(input logic [3:0] o, input int sa, input int sb, input int d,
                            input int n, output logic [1:0] fl);
      logic [DATA_W+1:0] rv;
      fl = 2'b00;
      for (int i = 0; i < n; i++) begin
         rv = alu_f(ref_rf[(sa + i) % 32], ref_rf[(sb + i) % 32], o);
         ref_rf[(d + i) % 32] = rv[DATA_W-1:0];
         fl = fl | rv[DATA_W+1:DATA_W];
         exp_q.push_back({8'(2 * (i + 1)), ADDR_W'(d + i), rv[DATA_W-1:0]});
      end
   endtask

   // Issues one command. It follows the command until done or the cycle budget
   // runs out. start is pulsed again in cycle restart_cyc (0 = never) and again
   // in the DONE cycle, and both pulses must be ignored.
   task automatic run_cmd(input logic [3:0] o, input int sa, input int sb, input int d,
                          input int l, input int exp_done, input int restart_cyc);
      logic [1:0]    fl;
      logic [EW-1:0] e;
      int            c;
      bit            fin;
      model_cmd(o, sa, sb, d, (l > 32) ? 32 : l, fl);
      @(negedge clk);
      op = o; src_a = ADDR_W'(sa); src_b = ADDR_W'(sb); dst = ADDR_W'(d);
      len = LEN_W'(l); start = 1'b1;
      c = 0;
      fin = 1'b0;
      while (!fin) begin
         @(posedge clk);
         c++;
         @(negedge clk);
         if (rf_we) begin
            if (exp_q.size() == 0) begin
               check("spurious_write", {c[7:0], rf_wa, rf_wd}, '0);
            end else begin
               e = exp_q.pop_front();
               check("write", {c[7:0], rf_wa, rf_wd}, e);
            end
         end
         check("busy_in_cmd", busy, 1'b1);
         if (done) begin
            check("done_cycle", c, exp_done);
            check("flags_acc", flags_acc, fl);
            fin = 1'b1;
         end else if (c > exp_done + 4) begin
            check("done_timeout", c, exp_done);
            fin = 1'b1;
         end
         start = (c == restart_cyc) || done;
      end
      check("missing_writes", exp_q.size(), 0);
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("idle_after_done", {busy, done, rf_we}, 3'b000);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [3:0] op;
      int         sa, sb, d, l;
      int         exp_done;
   } vec_t;
   vec_t vt[6];

   // ---------------- main sequence ----------------
   initial begin
      logic [1:0] fl;
      bit         we_seen;
      n_vec = 0; n_err = 0;
      rst_n = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0; dst = '0; len = '0;
      tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
`ifdef VSEQ_ABORT_EN
      abort = 1'b0;
`endif

      vt[0] = '{4'd0,  1,  5,  9,  4,  9};   // vector add
      vt[1] = '{4'd0,  7,  8,  9,  0,  1};   // len = 0
      vt[2] = '{4'd0, 30,  0, 29,  4,  9};   // address wrap
      vt[3] = '{4'd0,  3,  3,  4,  3,  7};   // chained overlap
      vt[4] = '{4'd4, 12, 20,  0, 40, 65};   // len saturated to 32, overlaps everything
      vt[5] = '{4'd1,  2,  3,  2,  5, 11};   // in-place subtract

      repeat (2) @(negedge clk);
      check("reset_ctrl", {busy, done, rf_we, flags_acc, alu_ctrl, rf_ra_a, rf_ra_b, rf_wa}, '0);
      check("reset_alu", {alu_a, alu_b}, '0);
      rst_n = 1'b1;

      for (int r = 0; r < 32; r++) set_reg(r, $urandom_range(1000, 1));
      for (int r = 1; r <= 4; r++) begin
         set_reg(r, DATA_W'(r));
         set_reg(r + 4, DATA_W'(10 * r));
      end

      for (int i = 0; i < 6; i++) begin
         if (i == 3) set_reg(3, 32'd5);
         run_cmd(vt[i].op, vt[i].sa, vt[i].sb, vt[i].d, vt[i].l, vt[i].exp_done, 0);
         if (i == 0) begin
            check("vadd_r9",  rf[9],  32'd11);
            check("vadd_r10", rf[10], 32'd22);
            check("vadd_r11", rf[11], 32'd33);
            check("vadd_r12", rf[12], 32'd44);
         end
         if (i == 1) check("len0_flags", flags_acc, 2'b00);
         if (i == 3) begin
            check("chain_r4", rf[4], 32'd10);
            check("chain_r5", rf[5], 32'd20);
            check("chain_r6", rf[6], 32'd40);
         end
      end
      for (int r = 0; r < 32; r++) check("rf_contents", rf[r], ref_rf[r]);

      // start again in cycle 3 of a len=4 command: still exactly 4 writes
      run_cmd(4'd0, 1, 5, 13, 4, 9, 3);

      // flags: only the middle element gives a zero result
      set_reg(20, 32'd7); set_reg(21, 32'd9); set_reg(22, 32'd3);
      set_reg(23, 32'd2); set_reg(24, 32'd9); set_reg(25, 32'd1);
      run_cmd(4'd1, 20, 23, 26, 3, 7, 0);
      check("flags_sticky", flags_acc, 2'b01);

      // reset in cycle 5 of a len=8 command
      model_cmd(4'd0, 1, 5, 16, 2, fl);
      exp_q.delete();
      @(negedge clk);
      op = 4'd0; src_a = 5'd1; src_b = 5'd5; dst = 5'd16; len = 6'd8; start = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         check("rst_seq_we", rf_we, (c == 2 || c == 4));
      end
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_ctrl", {busy, done, rf_we, flags_acc, alu_ctrl, rf_ra_a, rf_ra_b, rf_wa}, '0);
      check("rst_mid_alu", {alu_a, alu_b}, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      we_seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         we_seen = we_seen | rf_we;
      end
      check("rst_no_writes", we_seen, 1'b0);
      check("rst_idle", busy, 1'b0);
      check("rst_r16", rf[16], ref_rf[16]);
      check("rst_r17", rf[17], ref_rf[17]);
      check("rst_r18", rf[18], ref_rf[18]);

`ifdef VSEQ_ABORT_EN
      // abort in cycle 4 (second WRITE) of a len=4 command
      model_cmd(4'd0, 1, 5, 24, 1, fl);
      exp_q.delete();
      @(negedge clk);
      op = 4'd0; src_a = 5'd1; src_b = 5'd5; dst = 5'd24; len = 6'd4; start = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk);
         #1 abort = (c == 4);
         @(negedge clk);
         start = 1'b0;
         check("abort_we", rf_we, (c == 2));
         check("abort_done", done, (c == 5));
         check("abort_flag", aborted, (c >= 5));
      end
      check("abort_idle", busy, 1'b0);
      check("abort_r24", rf[24], ref_rf[24]);
      check("abort_r25", rf[25], ref_rf[25]);
      run_cmd(4'd0, 0, 0, 0, 0, 1, 0);
      check("abort_cleared", aborted, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/vect_op_sequencer.md
Name: vect_op_sequencer

Overview:
Sequences the shared vect_unit datapath over a run of consecutive CPU registers. A single start command streams operand pairs from the 32x32 register file through vect_unit and writes each result back. Removes the software loop the CPU otherwise needs to issue per-element vector ops. Sits between the CPU control/decode stage, the register-file read/write ports and the vect_unit A/B/aluCTRL inputs.

Parameters:
DATA_W, 32, operand/result width; must match vect_unit.
ADDR_W, 5, register address width (32 registers).
LEN_W, 6, width of element count; values 0..32 meaningful.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  command strobe; sampled only in IDLE.
op  in  4  aluCTRL code applied to every element.
src_a  in  ADDR_W  base register of operand A vector.
src_b  in  ADDR_W  base register of operand B vector.
dst  in  ADDR_W  base register of result vector.
len  in  LEN_W  element count.
busy  out  1  high in ISSUE/WRITE/DONE.
done  out  1  one-cycle pulse at end of command.
flags_acc  out  2  sticky OR of vect_unit flags over the command.
rf_ra_a  out  ADDR_W  register-file read address A.
rf_ra_b  out  ADDR_W  register-file read address B.
rf_rd_a  in  DATA_W  read data A (combinational read).
rf_rd_b  in  DATA_W  read data B (combinational read).
alu_a  out  DATA_W  registered operand A to vect_unit.
alu_b  out  DATA_W  registered operand B to vect_unit.
alu_ctrl  out  4  registered op to vect_unit.
alu_out  in  DATA_W  vect_unit result.
alu_flags  in  2  vect_unit flags.
rf_we  out  1  register-file write enable.
rf_wa  out  ADDR_W  write address.
rf_wd  out  DATA_W  write data (= alu_out).

Behaviour:
- Reset (rst_n=0, async): state IDLE; idx=0; busy=0, done=0, rf_we=0, flags_acc=0, alu_a=alu_b=0, alu_ctrl=0, rf_ra_a=rf_ra_b=rf_wa=0. Reset mid-command aborts with no further writes.
- IDLE: on start=1, latch op/src_a/src_b/dst; latch len saturated to 32; clear idx and flags_acc. Next state: ISSUE, or DONE if len=0.
- ISSUE (1 cycle): rf_ra_a=src_a+idx, rf_ra_b=src_b+idx (mod 32). At edge, alu_a<=rf_rd_a, alu_b<=rf_rd_b, alu_ctrl<=op. Next state: WRITE.
- WRITE (1 cycle): rf_we=1, rf_wa=dst+idx (mod 32), rf_wd=alu_out. At edge, flags_acc|=alu_flags. If idx=len-1, next state is DONE; otherwise idx++ and next state is ISSUE.
- DONE (1 cycle): done=1, busy=1, rf_we=0. Next state: IDLE.
- Timing: start accepted at edge 0. Write k (k=1..N) occurs in cycle 2k. done is asserted in cycle 2N+1. busy drops in cycle 2N+2. len=0 gives done in cycle 1 with no writes.
- Register-address wrap: 31+1 -> 0.
- Overlap: element i is read after element i-1 is written, so in-place and overlapping vectors follow strict sequential semantics.
- start while busy: ignored.
- start in the DONE cycle: ignored; it must be re-asserted in IDLE.
- A dst of register 0 is written like any other register; any write protection is the register file's responsibility.
- rf_we is never high outside WRITE.

Optional Feature:
VSEQ_ABORT_EN:
- Defined: adds input abort (1 bit) and output aborted (1 bit).
  - abort=1 in ISSUE, or in WRITE with no rf_we, forces next state DONE.
  - abort during WRITE suppresses rf_we in that cycle (combinationally gated).
  - aborted is set with done and held until the next accepted start or reset.
  - abort in IDLE or DONE has no effect.
- Undefined: neither port exists; commands always run to completion.

Test Plan:
- Vector add: R1..R4=1,2,3,4; R5..R8=10,20,30,40; op=ADD, src_a=1, src_b=5, dst=9, len=4 -> R9..R12=11,22,33,44; rf_we in cycles 2,4,6,8; done in cycle 9.
- len=0 with start -> done in cycle 1, rf_we never asserted, flags_acc=0.
- Wrap: src_a=30, src_b=0, dst=29, len=4 -> reads (30,0),(31,1),(0,2),(1,3); writes 29,30,31,0.
- Chained overlap: R3=5, op=ADD, src_a=3, src_b=3, dst=4, len=3 -> R4=10, R5=20, R6=40.
- start pulsed again in cycle 3 of a len=4 command -> ignored, exactly 4 writes; then flags: one element setting flag[0] -> flags_acc=2'b01 after done.
- rst_n low in cycle 5 of a len=8 command -> outputs zero immediately; no writes after cycle 4. With VSEQ_ABORT_EN: abort in cycle 4 -> no write in cycle 4, done and aborted=1 in cycle 5.
